// File: rtl/inst_fetch_queue_pkg.sv
// Shared core constants for the fetch path: bus widths, NOP encoding, hold levels, queue depth.
package inst_fetch_queue_pkg;

  localparam int          InstAddrBus   = 32;
  localparam int          Hold_Flag_Bus = 3;
  localparam logic [31:0] ZeroWord      = 32'h0000_0000;
  localparam logic [31:0] INST_NOP      = 32'h0000_0013;

  localparam logic [Hold_Flag_Bus-1:0] Hold_None = 3'b000;
  localparam logic [Hold_Flag_Bus-1:0] Hold_Pc   = 3'b001;
  localparam logic [Hold_Flag_Bus-1:0] Hold_If   = 3'b010;
  localparam logic [Hold_Flag_Bus-1:0] Hold_Id   = 3'b011;

  localparam int         IFQ_DEPTH     = 4;
  localparam logic [2:0] IFQ_COUNT_MAX = 3'(IFQ_DEPTH);
  localparam logic [2:0] IFQ_HOLD_LVL  = 3'(IFQ_DEPTH - 1);

endpackage

// File: rtl/inst_fetch_queue.sv
// 4-entry {pc, inst} queue between fetch and decode; entries appear one cycle after write.
// Asks ctrl to stall pc at 3 entries; a write into a full, non-draining queue is dropped and flagged.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     jtag_reset_flag_i,
  input  logic                     jump_flag_i,
  input  logic [Hold_Flag_Bus-1:0] hold_flag_i,
  input  logic [InstAddrBus-1:0]   pc_i,
  input  logic [31:0]              inst_i,
  input  logic                     inst_valid_i,
  input  logic                     id_ready_i,
  output logic [InstAddrBus-1:0]   pc_o,
  output logic [31:0]              inst_o,
  output logic                     inst_valid_o,
  output logic                     fetch_hold_o,
  output logic                     ovf_o
);

  logic [1:0]             rd_ptr;
  logic [1:0]             wr_ptr;
  logic [2:0]             count;
  logic                   ovf;
  logic [InstAddrBus-1:0] pc_mem   [IFQ_DEPTH];
  logic [31:0]            inst_mem [IFQ_DEPTH];

  logic any_rst;
  logic flush;
  logic rd_en;
  logic wr_en;
  logic drop;

  assign any_rst = rst | jtag_reset_flag_i;
  assign flush   = jump_flag_i;
  assign rd_en   = (count != 3'd0) && id_ready_i && (hold_flag_i < Hold_Id) && !flush;
  // A full queue still accepts a write when the head drains in the same cycle.
  assign wr_en   = inst_valid_i && !flush && ((count != IFQ_COUNT_MAX) || rd_en);
  assign drop    = inst_valid_i && !flush && (count == IFQ_COUNT_MAX) && !rd_en;

  always_ff @(posedge clk) begin
    if (any_rst) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
      ovf    <= 1'b0;
    end else if (flush) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 2'd1;
      if (rd_en) rd_ptr <= rd_ptr + 2'd1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

  // Storage is never reset; count=0 masks whatever it holds.
  always_ff @(posedge clk) begin
    if (wr_en && !any_rst) begin
      pc_mem[wr_ptr]   <= pc_i;
      inst_mem[wr_ptr] <= inst_i;
    end
  end

  assign inst_valid_o = (count != 3'd0);
  assign pc_o         = inst_valid_o ? pc_mem[rd_ptr]   : ZeroWord;
  assign inst_o       = inst_valid_o ? inst_mem[rd_ptr] : INST_NOP;
  assign fetch_hold_o = (count >= IFQ_HOLD_LVL);
  assign ovf_o        = ovf;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized and directed bench for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst, jtag_reset_flag_i, jump_flag_i, inst_valid_i, id_ready_i;
  logic [2:0]  hold_flag_i;
  logic [31:0] pc_i, inst_i;
  logic [31:0] pc_o, inst_o;
  logic        inst_valid_o, fetch_hold_o, ovf_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] mq[$];
  logic        m_ovf;

  always #5 clk = ~clk;

  inst_fetch_queue dut (
    .clk(clk), .rst(rst), .jtag_reset_flag_i(jtag_reset_flag_i),
    .jump_flag_i(jump_flag_i), .hold_flag_i(hold_flag_i),
    .pc_i(pc_i), .inst_i(inst_i), .inst_valid_i(inst_valid_i), .id_ready_i(id_ready_i),
    .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
    .fetch_hold_o(fetch_hold_o), .ovf_o(ovf_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference: a bounded queue; decisions taken from the pre-edge occupancy.
  task automatic model_edge();
    int  sz;
    bit  rd;
    sz = mq.size();
    if (rst || jtag_reset_flag_i) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (jump_flag_i) begin
      mq.delete();
    end else begin
      rd = (sz > 0) && id_ready_i && (hold_flag_i < 3'd3);
      if (rd) void'(mq.pop_front());
      if (inst_valid_i) begin
        if (sz < 4 || rd) mq.push_back({pc_i, inst_i});
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    bit ne;
    ne = (mq.size() > 0);
    chk("inst_valid_o", 32'(inst_valid_o), 32'(ne));
    chk("pc_o",         pc_o,   ne ? mq[0][63:32] : 32'h0);
    chk("inst_o",       inst_o, ne ? mq[0][31:0]  : 32'h0000_0013);
    chk("fetch_hold_o", 32'(fetch_hold_o), 32'(mq.size() >= 3));
    chk("ovf_o",        32'(ovf_o), 32'(m_ovf));
  endtask

  task automatic step(input logic r, input logic j, input logic jmp, input logic [2:0] hold,
                      input logic vld, input logic [31:0] pc, input logic [31:0] inst,
                      input logic rdy);
    rst = r; jtag_reset_flag_i = j; jump_flag_i = jmp; hold_flag_i = hold;
    inst_valid_i = vld; pc_i = pc; inst_i = inst; id_ready_i = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic wr(input logic [31:0] pc, input logic rdy);
    step(0, 0, 0, 3'd0, 1, pc, 32'h0010_0093 + (pc << 18), rdy);
  endtask

  task automatic idle(input logic rdy);
    step(0, 0, 0, 3'd0, 0, 32'h0, 32'h0, rdy);
  endtask

  initial begin
    mq.delete();
    m_ovf = 1'b0;
    rst = 1; jtag_reset_flag_i = 0; jump_flag_i = 0; hold_flag_i = 0;
    inst_valid_i = 0; pc_i = 0; inst_i = 0; id_ready_i = 0;
    @(posedge clk);
    step(1, 0, 0, 3'd0, 0, 32'h0, 32'h0, 0);
    chk("reset_inst_nop", inst_o, 32'h0000_0013);
    chk("reset_valid", 32'(inst_valid_o), 32'h0);

    // First fetch appears one cycle later, then entries stream in order.
    step(0, 0, 0, 3'd0, 1, 32'h0, 32'h0050_0093, 1);
    chk("first_pc", pc_o, 32'h0);
    chk("first_inst", inst_o, 32'h0050_0093);
    wr(32'h4, 1); wr(32'h8, 1); idle(1); idle(1);

    // Fill without draining, then overflow.
    wr(32'h10, 0); wr(32'h14, 0); wr(32'h18, 0);
    chk("hold_at_3", 32'(fetch_hold_o), 32'h1);
    wr(32'h1c, 0);
    wr(32'h20, 0);
    chk("ovf_set", 32'(ovf_o), 32'h1);
    idle(1); idle(0);
    chk("ovf_sticky", 32'(ovf_o), 32'h1);

    // Full with simultaneous read and write: stays full, head advances.
    step(1, 0, 0, 3'd0, 0, 32'h0, 32'h0, 0);
    wr(32'h40, 0); wr(32'h44, 0); wr(32'h48, 0); wr(32'h4c, 0);
    wr(32'h50, 1);
    chk("full_rw_head", pc_o, 32'h44);
    chk("full_rw_no_ovf", 32'(ovf_o), 32'h0);
    idle(1); idle(1); idle(1); idle(1); idle(1);

    // Flush at count 2 discards the same-cycle write.
    wr(32'h60, 0); wr(32'h64, 0);
    step(0, 0, 1, 3'd0, 1, 32'h68, 32'h1234_5678, 1);
    chk("flush_inst_nop", inst_o, 32'h0000_0013);
    wr(32'h80, 0);
    chk("post_flush_head", pc_o, 32'h80);

    // Hold at decode blocks reads; release drains one per cycle.
    wr(32'h84, 0);
    step(0, 0, 0, 3'd3, 0, 32'h0, 32'h0, 1);
    step(0, 0, 0, 3'd4, 0, 32'h0, 32'h0, 1);
    chk("hold_head", pc_o, 32'h80);
    step(0, 0, 0, 3'd2, 0, 32'h0, 32'h0, 1);
    idle(1);

    // Debug reset mid-stream.
    wr(32'h90, 0); wr(32'h94, 1);
    step(0, 1, 0, 3'd0, 1, 32'h98, 32'h9, 1);
    chk("jtag_pc", pc_o, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic [2:0] hold_r;
      logic rdy_r;
      hold_r = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 5)) : 3'd0;
      rdy_r  = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 19) == 0, hold_r,
           $urandom_range(0, 3) != 0, $urandom, $urandom, rdy_r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- jtag_reset_flag_i  in  1  debug reset, same effect as rst
- jump_flag_i  in  1  redirect from ex/ctrl, flushes queue
- hold_flag_i  in  `Hold_Flag_Bus (3)  ctrl hold level
- pc_i  in  32  address of instruction returned this cycle
- inst_i  in  32  fetched instruction word (mem read data)
- inst_valid_i  in  1  pc_i/inst_i pair valid this cycle
- id_ready_i  in  1  decode accepts head entry this cycle
- pc_o  out  32  head entry address
- inst_o  out  32  head entry instruction
- inst_valid_o  out  1  head entry valid
- fetch_hold_o  out  1  request to ctrl to stall pc
- ovf_o  out  1  sticky overflow error

Function
REQ-003 The block SHALL store up to 4 {pc, inst} entries in FIFO order using 2-bit rd/wr pointers and a 3-bit count (0..4).
REQ-004 Write SHALL occur when inst_valid_i=1, flush=0, and (count<4 or read this cycle).
REQ-005 Read SHALL occur when count>0, id_ready_i=1, hold_flag_i < `Hold_Id, and flush=0.
REQ-006 Flush SHALL be jump_flag_i=1; the next cycle SHALL have count=0 with pointers equal, and any same-cycle write SHALL be discarded.
REQ-007 Write latency SHALL be one cycle; an entry written at edge N SHALL be visible on the outputs after edge N, with no empty-queue bypass.
REQ-008 pc_o/inst_o SHALL be driven from the head-entry registers when count>0, and SHALL be 32'h0 and `INST_NOP (32'h00000013) when count=0.
REQ-009 inst_valid_o SHALL equal (count>0) and SHALL NOT depend combinationally on id_ready_i.
REQ-010 fetch_hold_o SHALL equal (count>=3), decoded from registered count, giving one slot of margin for the in-flight fetch.
REQ-011 If count=4, inst_valid_i=1, no read and no flush, the entry SHALL be dropped and ovf_o SHALL set and stay set until reset.
REQ-012 Simultaneous read and write SHALL leave count unchanged, including at count=4 and count=0->1 transitions (count=0 has no read).
REQ-013 Pointers SHALL wrap 3->0 without special handling.
REQ-014 Flush SHALL take priority over read and write; reset SHALL take priority over flush.

Reset
REQ-015 On rst or jtag_reset_flag_i at a clock edge: rd/wr pointers=0, count=0, ovf_o=0, inst_valid_o=0, fetch_hold_o=0, pc_o=0, inst_o=`INST_NOP.
REQ-016 Entry storage SHALL NOT require reset; its contents SHALL NOT be observable while count=0.
REQ-017 Reset during a read/write cycle SHALL discard both operations.

Structure
REQ-018 `ZeroWord, `INST_NOP, `Hold_Flag_Bus, `Hold_Pc, `Hold_If, `Hold_Id, `InstAddrBus and the queue-depth constant IFQ_DEPTH=4 SHALL live in the shared core defines file.
REQ-019 Storage and control SHALL be inline, with no sub-module; the expected size is 120-200 RTL lines.

Verification
REQ-020 Reset, then inst_valid_i=1 with pc_i=0x0/inst=0x00500093 and id_ready_i=1 -> next cycle inst_valid_o=1, pc_o=0x0, inst_o=0x00500093, with entries following in order.
REQ-021 id_ready_i=0 with 3 writes -> fetch_hold_o=1 after the 3rd write; a 4th write -> count=4; a 5th write -> dropped and ovf_o=1 (sticky).
REQ-022 count=4, simultaneous write and read -> count stays 4, the head advances by one, ovf_o=0.
REQ-023 count=2, jump_flag_i=1 with inst_valid_i=1 -> next cycle inst_valid_o=0, pc_o=0, inst_o=0x00000013; the next write is the first entry out.
REQ-024 count=2, hold_flag_i=`Hold_Id, id_ready_i=1 -> no read, head unchanged; releasing the hold -> one read per cycle.
REQ-025 Mid-stream jtag_reset_flag_i=1 for one cycle -> all outputs at reset values the following cycle.
